// File: rtl/midi_rx_pkg.sv
// midi_rx_pkg: shared MIDI constants, FSM state types and message helpers.
package midi_rx_pkg;
    localparam int MIDI_BAUD = 31_250;
    localparam logic [3:0] MIDI_NOTE_OFF = 4'h8;
    localparam logic [3:0] MIDI_NOTE_ON = 4'h9;
    localparam logic [3:0] MIDI_PGM = 4'hC;
    localparam logic [3:0] MIDI_CHPRESS = 4'hD;
    localparam logic [7:0] MIDI_SYS_MIN = 8'hF0;
    localparam logic [7:0] MIDI_RT_MIN = 8'hF8;
    typedef enum logic [2:0] {WAIT_IDLE, IDLE, START, DATA, STOP} rx_state_t;
    typedef enum logic [1:0] {NO_STATUS, WAIT_D1, WAIT_D2} parse_state_t;
    function automatic logic one_data(input logic [7:0] status);
        return status[7:4] == MIDI_PGM || status[7:4] == MIDI_CHPRESS;
    endfunction
endpackage

// File: rtl/midi_rx_if.sv
// midi_rx_if: serial MIDI line in, decoded note events out.
interface midi_rx_if;
    logic rxData_i;
    logic noteValid_o;
    logic noteOn_o;
    logic [6:0] noteNum_o;
    logic [6:0] velocity_o;
    logic frameErr_o;
    modport master(output rxData_i, input noteValid_o, noteOn_o, noteNum_o, velocity_o, frameErr_o);
    modport slave(input rxData_i, output noteValid_o, noteOn_o, noteNum_o, velocity_o, frameErr_o);
endinterface

// File: rtl/midi_uart_rx.sv
// midi_uart_rx: 2-FF line synchroniser and 8N1 UART receive FSM.
module midi_uart_rx
    import midi_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 32
) (
    input  logic       clk_i,
    input  logic       nrst_i,
    input  logic       rxData_i,
    output logic [7:0] data_o,
    output logic       byteValid_o,
    output logic       frameErr_o
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2);
    logic [1:0] sync;
    logic line;
    rx_state_t state;
    logic [CW-1:0] cnt;
    logic [2:0] idx;
    assign line = sync[1];
    // cnt counts down to the next sample point; every reload is <= CLKS_PER_BIT-1
    always_ff @(posedge clk_i) begin
        if (!nrst_i) begin
            sync <= 2'b11;
            state <= WAIT_IDLE;
            cnt <= '0;
            idx <= '0;
            data_o <= '0;
            byteValid_o <= 1'b0;
            frameErr_o <= 1'b0;
        end else begin
            sync <= {sync[0], rxData_i};
            byteValid_o <= 1'b0;
            frameErr_o <= 1'b0;
            case (state)
                WAIT_IDLE: if (line) state <= IDLE;
                IDLE: if (!line) begin
                    state <= START;
                    cnt <= HALF;
                end
                START: if (cnt != '0) cnt <= cnt - CW'(1);
                else begin
                    state <= line ? IDLE : DATA;
                    cnt <= FULL;
                    idx <= '0;
                end
                DATA: if (cnt != '0) cnt <= cnt - CW'(1);
                else begin
                    data_o <= {line, data_o[7:1]};
                    cnt <= FULL;
                    idx <= idx + 3'd1;
                    if (idx == 3'd7) state <= STOP;
                end
                STOP: if (cnt != '0) cnt <= cnt - CW'(1);
                else begin
                    byteValid_o <= line;
                    frameErr_o <= !line;
                    state <= line ? IDLE : WAIT_IDLE;
                end
                default: state <= WAIT_IDLE;
            endcase
        end
    end
endmodule

// File: rtl/midi_rx.sv
// midi_rx: MIDI byte parser with running status, channel filter and note-event output registers.
module midi_rx
    import midi_rx_pkg::*;
#(
    parameter int CLK_HZ = 50_000_000,
    parameter int BAUD = MIDI_BAUD,
    parameter bit OMNI = 1'b1,
    parameter logic [3:0] CHANNEL = 4'd0
) (
    input logic clk_i,
    input logic nrst_i,
    midi_rx_if.slave bus
);
    localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
    logic [7:0] rx_byte;
    logic byte_valid;
    parse_state_t state;
    logic [7:0] status;
    logic [6:0] d1;
    logic hit;
    midi_uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_uart (
        .clk_i(clk_i),
        .nrst_i(nrst_i),
        .rxData_i(bus.rxData_i),
        .data_o(rx_byte),
        .byteValid_o(byte_valid),
        .frameErr_o(bus.frameErr_o)
    );
    assign hit = (status[7:4] == MIDI_NOTE_OFF || status[7:4] == MIDI_NOTE_ON) && (OMNI || status[3:0] == CHANNEL);
    // realtime bytes never reach the parser; system bytes park it in NO_STATUS
    always_ff @(posedge clk_i) begin
        if (!nrst_i) begin
            state <= NO_STATUS;
            status <= '0;
            d1 <= '0;
            bus.noteValid_o <= 1'b0;
            bus.noteOn_o <= 1'b0;
            bus.noteNum_o <= '0;
            bus.velocity_o <= '0;
        end else begin
            bus.noteValid_o <= 1'b0;
            if (byte_valid && rx_byte < MIDI_RT_MIN) begin
                if (rx_byte[7]) begin
                    status <= rx_byte;
                    state <= rx_byte >= MIDI_SYS_MIN ? NO_STATUS : WAIT_D1;
                end else if (state == WAIT_D1 && !one_data(status)) begin
                    d1 <= rx_byte[6:0];
                    state <= WAIT_D2;
                end else if (state != NO_STATUS) begin
                    state <= WAIT_D1;
                    if (state == WAIT_D2 && hit) begin
                        bus.noteValid_o <= 1'b1;
                        bus.noteOn_o <= status[7:4] == MIDI_NOTE_ON && rx_byte[6:0] != 7'd0;
                        bus.noteNum_o <= d1;
                        bus.velocity_o <= rx_byte[6:0];
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_midi_rx.sv
// tb_midi_rx: table-driven, corner-case and randomized checks of midi_rx (OMNI and channel-0 instances).
module tb_midi_rx;
    localparam int CPB = 32;
    // start edge to strobe: 9.5 bit times to the stop-bit centre, plus sync, start detect and 2-cycle latency
    localparam int LAT = 9 * CPB + CPB / 2 + 5;
    typedef struct packed {logic on; logic [6:0] num; logic [6:0] vel;} ev_t;
    typedef struct {logic [7:0] b[6]; int n; int n_omni; int n_ch0; ev_t e[2];} vec_t;
    logic clk = 1'b0, nrst = 1'b0, line = 1'b1;
    int cyc = 0, last_start = 0, total = 0, bad = 0, fe0 = 0, fe1 = 0, longs = 0;
    logic pv0 = 0, pf0 = 0, pv1 = 0, pf1 = 0;
    ev_t obs0[$], obs1[$];
    int obs_cyc[$];
    int m_st[2];
    logic [7:0] m_d[2][$];
    ev_t ex[2][$];
    vec_t v[6];
    logic [3:0] his[8];
    midi_rx_if bus0();
    midi_rx_if bus1();
    assign bus0.rxData_i = line;
    assign bus1.rxData_i = line;
    midi_rx #(.CLK_HZ(1_000_000), .BAUD(31_250), .OMNI(1'b1), .CHANNEL(4'd0)) dut0 (.clk_i(clk), .nrst_i(nrst), .bus(bus0));
    midi_rx #(.CLK_HZ(1_000_000), .BAUD(31_250), .OMNI(1'b0), .CHANNEL(4'd0)) dut1 (.clk_i(clk), .nrst_i(nrst), .bus(bus1));
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (bus0.noteValid_o) begin
            obs0.push_back({bus0.noteOn_o, bus0.noteNum_o, bus0.velocity_o});
            obs_cyc.push_back(cyc);
        end
        if (bus1.noteValid_o) obs1.push_back({bus1.noteOn_o, bus1.noteNum_o, bus1.velocity_o});
        if (bus0.frameErr_o) fe0++;
        if (bus1.frameErr_o) fe1++;
        if ((bus0.noteValid_o && pv0) || (bus0.frameErr_o && pf0) || (bus1.noteValid_o && pv1) || (bus1.frameErr_o && pf1)) longs++;
        pv0 = bus0.noteValid_o;
        pf0 = bus0.frameErr_o;
        pv1 = bus1.noteValid_o;
        pf1 = bus1.frameErr_o;
    end
    function automatic ev_t mk(input logic on, input int num, input int vel);
        ev_t e;
        e.on = on;
        e.num = 7'(num);
        e.vel = 7'(vel);
        return e;
    endfunction
    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask
    task automatic check_zero(input string name);
        check({name, "0"}, int'({bus0.noteValid_o, bus0.noteOn_o, bus0.noteNum_o, bus0.velocity_o, bus0.frameErr_o}), 0);
        check({name, "1"}, int'({bus1.noteValid_o, bus1.noteOn_o, bus1.noteNum_o, bus1.velocity_o, bus1.frameErr_o}), 0);
    endtask
    task automatic send(input logic [7:0] b, input logic stop, input int rst_bit);
        @(negedge clk);
        line = 1'b0;
        last_start = cyc;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            line = b[i];
            if (i == rst_bit) begin
                repeat (CPB / 2) @(negedge clk);
                nrst = 1'b0;
                @(negedge clk);
                nrst = 1'b1;
                check_zero("midframe_rst_outs");
                repeat (CPB - CPB / 2 - 1) @(negedge clk);
            end else repeat (CPB) @(negedge clk);
        end
        line = stop;
        repeat (CPB) @(negedge clk);
        line = 1'b1;
        repeat (2) @(negedge clk);
    endtask
    task automatic idle(input int bits);
        repeat (bits * CPB) @(negedge clk);
    endtask
    task automatic clear();
        obs0.delete();
        obs1.delete();
        obs_cyc.delete();
        fe0 = 0;
        fe1 = 0;
    endtask
    task automatic do_reset();
        @(negedge clk);
        nrst = 1'b0;
        repeat (2) @(negedge clk);
        nrst = 1'b1;
        clear();
    endtask
    // reference: a message completes once the status's data-byte quota is collected
    task automatic model(input logic [7:0] b);
        for (int k = 0; k < 2; k++) begin
            if (b >= 8'hF8) continue;
            if (b >= 8'hF0) m_st[k] = -1;
            else if (b[7]) m_st[k] = int'(b);
            if (b[7]) begin
                m_d[k].delete();
                continue;
            end
            if (m_st[k] < 0) continue;
            m_d[k].push_back(b);
            if (m_d[k].size() == (((m_st[k] >> 4) == 12 || (m_st[k] >> 4) == 13) ? 1 : 2)) begin
                if (((m_st[k] >> 4) == 8 || (m_st[k] >> 4) == 9) && (k == 0 || (m_st[k] & 15) == 0))
                    ex[k].push_back(mk((m_st[k] >> 4) == 9 && m_d[k][1] != 0, int'(m_d[k][0]), int'(m_d[k][1])));
                m_d[k].delete();
            end
        end
    endtask
    initial begin
        v[0] = '{b: '{8'h90, 8'h3C, 8'h64, 8'h0, 8'h0, 8'h0}, n: 3, n_omni: 1, n_ch0: 1, e: '{mk(1, 60, 100), mk(0, 0, 0)}};
        v[1] = '{b: '{8'h90, 8'h40, 8'h50, 8'h43, 8'h00, 8'h0}, n: 5, n_omni: 2, n_ch0: 2, e: '{mk(1, 64, 80), mk(0, 67, 0)}};
        v[2] = '{b: '{8'h80, 8'hF8, 8'h3C, 8'hFE, 8'h40, 8'h0}, n: 5, n_omni: 1, n_ch0: 1, e: '{mk(0, 60, 64), mk(0, 0, 0)}};
        v[3] = '{b: '{8'h91, 8'h3C, 8'h64, 8'h0, 8'h0, 8'h0}, n: 3, n_omni: 1, n_ch0: 0, e: '{mk(1, 60, 100), mk(0, 0, 0)}};
        v[4] = '{b: '{8'hB0, 8'h07, 8'h7F, 8'h0, 8'h0, 8'h0}, n: 3, n_omni: 0, n_ch0: 0, e: '{mk(0, 0, 0), mk(0, 0, 0)}};
        v[5] = '{b: '{8'h80, 8'h3C, 8'h00, 8'h0, 8'h0, 8'h0}, n: 3, n_omni: 1, n_ch0: 1, e: '{mk(0, 60, 0), mk(0, 0, 0)}};
        his = '{4'h8, 4'h9, 4'h9, 4'h8, 4'hC, 4'hD, 4'hB, 4'hE};
        repeat (3) @(negedge clk);
        check_zero("reset_outs");
        nrst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            do_reset();
            for (int j = 0; j < v[i].n; j++) send(v[i].b[j], 1'b1, -1);
            idle(2);
            check($sformatf("vec%0d_n_omni", i), obs0.size(), v[i].n_omni);
            check($sformatf("vec%0d_n_ch0", i), obs1.size(), v[i].n_ch0);
            for (int k = 0; k < v[i].n_omni; k++)
                check($sformatf("vec%0d_ev%0d_omni", i, k), k < obs0.size() ? int'(obs0[k]) : -1, int'(v[i].e[k]));
            for (int k = 0; k < v[i].n_ch0; k++)
                check($sformatf("vec%0d_ev%0d_ch0", i, k), k < obs1.size() ? int'(obs1[k]) : -1, int'(v[i].e[k]));
            if (v[i].n_omni > 0) begin
                check($sformatf("vec%0d_latency", i), obs_cyc.size() > 0 ? obs_cyc[$] - last_start : -1, LAT);
                check($sformatf("vec%0d_hold", i), int'({bus0.noteNum_o, bus0.velocity_o}),
                      int'({v[i].e[v[i].n_omni-1].num, v[i].e[v[i].n_omni-1].vel}));
            end
        end
        do_reset();
        send(8'h90, 1'b0, -1);
        idle(1);
        check("ferr_pulse0", fe0, 1);
        check("ferr_pulse1", fe1, 1);
        check("ferr_no_event", obs0.size(), 0);
        send(8'h3C, 1'b1, -1);
        send(8'h64, 1'b1, -1);
        idle(2);
        check("ferr_no_status", obs0.size() + obs1.size(), 0);
        clear();
        @(negedge clk);
        line = 1'b0;
        repeat (8) @(negedge clk);
        line = 1'b1;
        idle(12);
        check("glitch_quiet", obs0.size() + obs1.size() + fe0 + fe1, 0);
        do_reset();
        send(8'h90, 1'b1, -1);
        send(8'h3C, 1'b1, -1);
        send(8'h64, 1'b1, -1);
        send(8'h90, 1'b1, -1);
        send(8'h3C, 1'b1, 3);
        idle(12);
        clear();
        send(8'h3C, 1'b1, -1);
        send(8'h64, 1'b1, -1);
        idle(2);
        check("rst_cleared_status", obs0.size() + obs1.size(), 0);
        send(8'h90, 1'b1, -1);
        send(8'h3C, 1'b1, -1);
        send(8'h64, 1'b1, -1);
        idle(2);
        check("rst_recover_n", obs0.size(), 1);
        check("rst_recover_ev", obs0.size() > 0 ? int'(obs0[0]) : -1, int'(mk(1, 60, 100)));
        check("rst_recover_ch0", obs1.size() > 0 ? int'(obs1[0]) : -1, int'(mk(1, 60, 100)));
        do_reset();
        for (int k = 0; k < 2; k++) begin
            m_st[k] = -1;
            m_d[k].delete();
            ex[k].delete();
        end
        begin
            int nerr = 0;
            for (int i = 0; i < 80; i++) begin
                logic [7:0] b;
                logic stop;
                int r;
                r = int'($urandom_range(0, 99));
                if (r < 45) b = ($urandom_range(0, 9) == 0) ? 8'h00 : {1'b0, 7'($urandom())};
                else if (r < 75) b = {his[$urandom_range(0, 7)], $urandom_range(0, 1) ? 4'h0 : 4'($urandom())};
                else if (r < 88) b = {5'b11111, 3'($urandom())};
                else b = {5'b11110, 3'($urandom())};
                stop = $urandom_range(0, 19) != 0;
                send(b, stop, -1);
                if (stop) model(b);
                else nerr++;
            end
            idle(2);
            check("rand_ferr", fe0, nerr);
            for (int k = 0; k < 2; k++) begin
                check($sformatf("rand_n%0d", k), k == 0 ? obs0.size() : obs1.size(), ex[k].size());
                for (int j = 0; j < ex[k].size(); j++)
                    check($sformatf("rand_ev%0d_%0d", k, j),
                          k == 0 ? (j < obs0.size() ? int'(obs0[j]) : -1) : (j < obs1.size() ? int'(obs1[j]) : -1),
                          int'(ex[k][j]));
            end
        end
        check("one_cycle_pulses", longs, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
